jk_sync_counter: RTL and testbench



---
 rtl/jk_pkg.sv | 29 ++
 rtl/jk_ff_bit.sv | 36 +++
 rtl/jk_sync_counter.sv | 63 ++++++
 tb/tb_jk_sync_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK command encodings and next-count helper
// for the JK-cell based synchronous counter.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Wrapping up/down step; m is the modulus, up to 2**16.
  function automatic logic [15:0] jk_next(
    input logic [15:0] q,
    input logic        up,
    input logic [16:0] m
  );
    logic [16:0] qe;
    logic [16:0] mm1;
    qe  = {1'b0, q};
    mm1 = m - 17'd1;
    if (up) begin
      if (qe >= mm1) return 16'd0;
      else           return q + 16'd1;
    end else begin
      if (q == 16'd0 || qe >= m) return mm1[15:0];
      else                       return q - 16'd1;
    end
  endfunction

endpackage

// File: rtl/jk_ff_bit.sv
// Single JK flip-flop cell with synchronous
// active-high reset and complementary output.
module jk_ff_bit
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Qb
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case ({J, K})
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign Q  = q_q;
  assign Qb = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-N up/down counter; each bit is a JK cell
// steered from the current count toward the next.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  localparam logic [16:0] MOD =
    17'(MODULUS);
  localparam logic [WIDTH-1:0] QMAX =
    WIDTH'(MODULUS - 1);

  logic [15:0]      nxt_w;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             unused_nxt;

  assign nxt_w      = jk_next(16'(q), up, MOD);
  assign nxt        = nxt_w[WIDTH-1:0];
  assign unused_nxt = ^nxt_w;

  // Load forces set/reset; counting toggles only the bits that differ.
  always_comb begin
    j = '0;
    k = '0;
    if (load) begin
      j = d;
      k = ~d;
    end else if (en) begin
      j = q ^ nxt;
      k = q ^ nxt;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_bit u_ff (
      .clk (clk),
      .rst (rst),
      .J   (j[i]),
      .K   (k[i]),
      .Q   (q[i]),
      .Qb  (qb[i])
    );
  end

  assign tc = ~rst & en & ~load &
              ((up & (q == QMAX)) |
               (~up & (q == '0)));

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench: a mod-10 and a mod-16 counter
// share stimulus; each vector selects which is checked.
module tb_jk_sync_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d = 4'd0;

  logic [3:0] q10, qb10, q16, qb16;
  logic       tc10, tc16;

  typedef struct {
    string      name;
    logic       sel;
    logic [3:0] q;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_d10 (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .d(d),
    .q(q10), .qb(qb10), .tc(tc10)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(16)) u_d16 (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .d(d),
    .q(q16), .qb(qb16), .tc(tc16)
  );

  task automatic step(
    input string      name,
    input logic       sel,
    input logic       r,
    input logic       e,
    input logic       u,
    input logic       l,
    input logic [3:0] dv,
    input logic [3:0] eq,
    input logic       etc
  );
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e;
    up   = u;
    load = l;
    d    = dv;
    x.name = name;
    x.sel  = sel;
    x.q    = eq;
    x.tc   = etc;
    exp_q.push_back(x);
  endtask

  // Monitor: tc before the edge, q/qb after it.
  initial begin
    exp_t x;
    logic [3:0] aq, aqb;
    logic       atc;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        x = exp_q[0];
        atc = x.sel ? tc16 : tc10;
        tests++;
        if (atc !== x.tc) begin
          fails++;
          $display("FAIL %s tc: got %b want %b",
                   x.name, atc, x.tc);
        end
        @(posedge clk);
        #1;
        aq  = x.sel ? q16 : q10;
        aqb = x.sel ? qb16 : qb10;
        tests++;
        if (aq !== x.q) begin
          fails++;
          $display("FAIL %s q: got %0d want %0d",
                   x.name, aq, x.q);
        end
        tests++;
        if (aqb !== ~x.q) begin
          fails++;
          $display("FAIL %s qb: got %b want %b",
                   x.name, aqb, ~x.q);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int budget;
    // reset and hold
    step("rst0", 0, 1, 0, 1, 0, 4'd0, 4'd0, 0);
    step("rst1", 0, 1, 1, 1, 0, 4'd0, 4'd0, 0);
    step("idle0", 0, 0, 0, 1, 0, 4'd0, 4'd0, 0);
    step("idle1", 0, 0, 0, 1, 0, 4'd0, 4'd0, 0);
    // up count 0 -> 1..9,0,1,2
    step("up1", 0, 0, 1, 1, 0, 4'd0, 4'd1, 0);
    step("up2", 0, 0, 1, 1, 0, 4'd0, 4'd2, 0);
    step("up3", 0, 0, 1, 1, 0, 4'd0, 4'd3, 0);
    step("up4", 0, 0, 1, 1, 0, 4'd0, 4'd4, 0);
    step("up5", 0, 0, 1, 1, 0, 4'd0, 4'd5, 0);
    step("up6", 0, 0, 1, 1, 0, 4'd0, 4'd6, 0);
    step("up7", 0, 0, 1, 1, 0, 4'd0, 4'd7, 0);
    step("up8", 0, 0, 1, 1, 0, 4'd0, 4'd8, 0);
    step("up9", 0, 0, 1, 1, 0, 4'd0, 4'd9, 0);
    step("upwrap", 0, 0, 1, 1, 0, 4'd0, 4'd0, 1);
    step("up1b", 0, 0, 1, 1, 0, 4'd0, 4'd1, 0);
    step("up2b", 0, 0, 1, 1, 0, 4'd0, 4'd2, 0);
    // down count from 2
    step("ld2", 0, 0, 1, 1, 1, 4'd2, 4'd2, 0);
    step("dn1", 0, 0, 1, 0, 0, 4'd0, 4'd1, 0);
    step("dn0", 0, 0, 1, 0, 0, 4'd0, 4'd0, 0);
    step("dnwrap", 0, 0, 1, 0, 0, 4'd0, 4'd9, 1);
    step("dn8", 0, 0, 1, 0, 0, 4'd0, 4'd8, 0);
    // load priority and out-of-range values
    step("ld5", 0, 0, 0, 0, 1, 4'd5, 4'd5, 0);
    step("ld12", 0, 0, 1, 1, 1, 4'd12, 4'd12, 0);
    step("oorup", 0, 0, 1, 1, 0, 4'd0, 4'd0, 0);
    step("ld12b", 0, 0, 1, 1, 1, 4'd12, 4'd12, 0);
    step("oordn", 0, 0, 1, 0, 0, 4'd0, 4'd9, 0);
    // reset mid-count beats load
    step("ld7", 0, 0, 1, 1, 1, 4'd7, 4'd7, 0);
    step("rstmid", 0, 1, 1, 1, 1, 4'd3, 4'd0, 0);
    step("resume", 0, 0, 1, 1, 0, 4'd0, 4'd1, 0);
    step("hold", 0, 0, 0, 1, 0, 4'd6, 4'd1, 0);
    // full-width modulus 16
    step("w_ld14", 1, 0, 1, 1, 1, 4'd14, 4'd14, 0);
    step("w_up15", 1, 0, 1, 1, 0, 4'd0, 4'd15, 0);
    step("w_wrap", 1, 0, 1, 1, 0, 4'd0, 4'd0, 1);
    step("w_dn15", 1, 0, 1, 0, 0, 4'd0, 4'd15, 1);
    step("w_up0", 1, 0, 1, 1, 0, 4'd0, 4'd0, 1);
    @(negedge clk);
    en   = 1'b0;
    load = 1'b0;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
